// File: rtl/exibidor_sequencia.sv
// Output-side sequencer of the memory game: plays the stored move sequence
// on the player LEDs for addresses 0..limite, then pulses pronto and returns
// to idle. Sequence memory has a one-cycle synchronous read.
module exibidor_sequencia #(
  parameter int unsigned TEMPO_LED       = 500,
  parameter int unsigned TEMPO_INTERVALO = 250,
  parameter int unsigned LARGURA_CONT    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       rapido,
  input  logic [3:0] limite,
  input  logic [3:0] dado_memoria,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  // Fast mode halves both times, floored, never below one cycle.
  localparam int unsigned LedRapido = (TEMPO_LED / 2 < 1) ? 1 : TEMPO_LED / 2;
  localparam int unsigned IntRapido = (TEMPO_INTERVALO / 2 < 1) ? 1 : TEMPO_INTERVALO / 2;

  // Terminal counts (time - 1) so the counter runs 0..time-1.
  localparam logic [LARGURA_CONT-1:0] FimLedNormal = LARGURA_CONT'(TEMPO_LED - 1);
  localparam logic [LARGURA_CONT-1:0] FimLedRapido = LARGURA_CONT'(LedRapido - 1);
  localparam logic [LARGURA_CONT-1:0] FimIntNormal = LARGURA_CONT'(TEMPO_INTERVALO - 1);
  localparam logic [LARGURA_CONT-1:0] FimIntRapido = LARGURA_CONT'(IntRapido - 1);

  typedef enum logic [2:0] {
    StInicial   = 3'b000,
    StCarrega   = 3'b001,
    StLe        = 3'b010,
    StMostra    = 3'b011,
    StIntervalo = 3'b100,
    StProximo   = 3'b101,
    StFim       = 3'b110
  } estado_e;

  estado_e                  r_estado;
  estado_e                  w_prox;
  logic [3:0]               r_endereco;
  logic [3:0]               r_limite;
  logic                     r_rapido;
  logic [3:0]               r_dado;
  logic [3:0]               r_leds;
  logic [LARGURA_CONT-1:0]  r_cont;
  logic                     w_fim_led;
  logic                     w_fim_int;

  assign w_fim_led = (r_cont == (r_rapido ? FimLedRapido : FimLedNormal));
  assign w_fim_int = (r_cont == (r_rapido ? FimIntRapido : FimIntNormal));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= StInicial;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state logic.
  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      StInicial:   if (iniciar) w_prox = StCarrega;
      StCarrega:   w_prox = StLe;
      StLe:        w_prox = StMostra;
      StMostra:    if (w_fim_led) w_prox = StIntervalo;
      StIntervalo: if (w_fim_int) w_prox = StProximo;
      StProximo:   w_prox = (r_endereco == r_limite) ? StFim : StCarrega;
      StFim:       w_prox = StInicial;
      default:     w_prox = StInicial;
    endcase
  end

  // Datapath: address, latched operands, move register, timing counter, LEDs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_endereco <= '0;
      r_limite   <= '0;
      r_rapido   <= 1'b0;
      r_dado     <= '0;
      r_cont     <= '0;
      r_leds     <= '0;
    end else begin
      unique case (r_estado)
        StInicial: begin
          r_endereco <= '0;
          if (iniciar) begin
            r_limite <= limite;
            r_rapido <= rapido;
          end
        end
        StLe: begin
          r_dado <= dado_memoria;
          r_cont <= '0;
        end
        StMostra:    r_cont <= w_fim_led ? '0 : r_cont + 1'b1;
        StIntervalo: r_cont <= w_fim_int ? '0 : r_cont + 1'b1;
        StProximo:   if (r_endereco != r_limite) r_endereco <= r_endereco + 4'd1;
        StFim:       r_endereco <= '0;
        default:     ;
      endcase
      // LEDs registered off the next state so they are lit exactly in MOSTRA;
      // on entry from LE the move is taken straight from the memory bus.
      if (w_prox == StMostra) begin
        r_leds <= (r_estado == StLe) ? dado_memoria : r_dado;
      end else begin
        r_leds <= '0;
      end
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    ocupado   = (r_estado != StInicial);
    pronto    = (r_estado == StFim);
    db_estado = r_estado;
  end

  assign endereco = r_endereco;
  assign leds     = r_leds;

endmodule
